// File: rtl/instr_issue_reader.sv
// -----------------------------------------------------------------------------
// instr_issue_reader
//
// Circular instruction buffer feeding a registered issue stage. Instructions
// are written in with wr_en/Instr_in and issued in write order through the
// Instr_out register with a valid/ready handshake (out_valid/out_ready).
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset (highest priority)
//   wr_en      : write request for Instr_in
//   Instr_in   : instruction to store
//   flush      : discard stored and issued-but-unaccepted instructions
//   out_ready  : downstream accepts Instr_out this cycle
//   Instr_out  : registered issued instruction
//   out_valid  : Instr_out holds a valid instruction
//   count      : entries in storage, excluding the output register
//   full       : count == bs
//   empty      : count == 0
//   overflow   : sticky, set by a write attempted while full
// -----------------------------------------------------------------------------
module instr_issue_reader #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             flush,
    input  logic                             out_ready,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             out_valid,
    output logic [$clog2(bs):0]              count,
    output logic                             full,
    output logic                             empty,
    output logic                             overflow
);

    localparam int AW = $clog2(bs);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] BS_CNT = CW'(bs);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [Instruction_word_size-1:0] mem_q [bs];
    logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [Instruction_word_size-1:0] instr_out_q, instr_out_d;
    logic                             overflow_q, overflow_d;
    logic                             wr_accept;
    logic                             load;

    // Status is derived purely from registered state.
    assign full      = (count_q == BS_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign Instr_out = instr_out_q;
    assign out_valid = (state_q == ISSUE);
    assign overflow  = overflow_q;

    // Full is sampled at cycle start, so a simultaneous pop does not make
    // room for a write in the same cycle.
    assign wr_accept = wr_en & ~full & ~flush;
    // Refill the output register when it is empty or being consumed.
    assign load      = (count_q != '0) & ((state_q == IDLE) | out_ready) & ~flush;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_out_d = instr_out_q;
        overflow_d  = overflow_q;

        if (flush) begin
            // Instr_out deliberately keeps its last value.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            state_d    = IDLE;
            overflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end

            if (load) begin
                instr_out_d = mem_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + AW'(1);
                state_d     = ISSUE;
            end else if ((state_q == ISSUE) && out_ready && (count_q == '0)) begin
                state_d = IDLE;
            end

            case ({wr_accept, load})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            instr_out_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_out_q <= instr_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array: no reset, contents are meaningless once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= Instr_in;
        end
    end

endmodule
